// File: rtl/parking_occupancy_pkg.sv
// Shared types and limits for the parking occupancy counter.
// Build option PARKING_STATS_EN adds peak/total statistics to the interface and top.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } occ_state_t;

    localparam int MAX_BCD_CAPACITY = 99;
    localparam int STATS_W          = 16;

endpackage

// File: rtl/parking_occupancy_if.sv
// Detector-to-display bundle for parking_occupancy; stats signals exist only with PARKING_STATS_EN.
interface parking_occupancy_if
    import parking_pkg::*;
#(
    parameter int CAPACITY = 25
);
    localparam int CW = $clog2(CAPACITY + 1);

    logic          enter;
    logic          exit;
    logic          clear_err;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          err_overflow;
    logic          err_underflow;
    logic [3:0]    bcd_tens;
    logic [3:0]    bcd_ones;
`ifdef PARKING_STATS_EN
    logic [CW-1:0]      peak;
    logic [STATS_W-1:0] total_entries;
`endif

    modport master (
        output enter, exit, clear_err,
        input  count, empty, full, err_overflow, err_underflow, bcd_tens, bcd_ones
`ifdef PARKING_STATS_EN
        , input peak, total_entries
`endif
    );

    modport slave (
        input  enter, exit, clear_err,
        output count, empty, full, err_overflow, err_underflow, bcd_tens, bcd_ones
`ifdef PARKING_STATS_EN
        , output peak, total_entries
`endif
    );

endinterface

// File: rtl/parking_occupancy_bcd.sv
// Combinational binary-to-BCD split of a 0..99 occupancy value into tens and ones digits.
module occupancy_to_bcd (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    always_comb begin
        tens = 4'(bin / 7'd10);
        ones = 4'(bin % 7'd10);
    end

endmodule

// File: rtl/parking_occupancy.sv
// Lot occupancy counter driven by enter/exit pulses, with status, sticky errors and BCD digits.
// Defining PARKING_STATS_EN adds the peak and total_entries statistics registers.
module parking_occupancy
    import parking_pkg::*;
#(
    parameter int CAPACITY = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    parking_occupancy_if.slave    bus
);

    localparam int            CW       = $clog2(CAPACITY + 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] CAP_LAST = CW'(CAPACITY - 1);

    generate
        if (CAPACITY < 1 || CAPACITY > MAX_BCD_CAPACITY) begin : g_cap_check
            $error("parking_occupancy: CAPACITY must be within 1..99");
        end
    endgenerate

    occ_state_t    state;
    logic [CW-1:0] count_q;
    logic          err_ovf_q;
    logic          err_unf_q;
    logic [3:0]    tens_q;
    logic [3:0]    ones_q;
    logic [3:0]    tens_c;
    logic [3:0]    ones_c;
    logic          add_ok;
    logic          sub_ok;
    logic          ovf_hit;
    logic          unf_hit;

    // A simultaneous enter and exit cancels out, so only lone pulses move the count.
    always_comb begin
        add_ok  = bus.enter && !bus.exit && (state != ST_FULL);
        sub_ok  = bus.exit && !bus.enter && (state != ST_EMPTY);
        ovf_hit = bus.enter && !bus.exit && (state == ST_FULL);
        unf_hit = bus.exit && !bus.enter && (state == ST_EMPTY);
    end

    occupancy_to_bcd u_bcd (
        .bin  (7'(count_q)),
        .tens (tens_c),
        .ones (ones_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_EMPTY;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
        end else begin
            if (add_ok) begin
                count_q <= count_q + ONE;
                state   <= (count_q == CAP_LAST) ? ST_FULL : ST_PARTIAL;
            end else if (sub_ok) begin
                count_q <= count_q - ONE;
                state   <= (count_q == ONE) ? ST_EMPTY : ST_PARTIAL;
            end
            // A fresh error in the clearing cycle must survive the clear.
            err_ovf_q <= (err_ovf_q && !bus.clear_err) || ovf_hit;
            err_unf_q <= (err_unf_q && !bus.clear_err) || unf_hit;
            tens_q    <= tens_c;
            ones_q    <= ones_c;
        end
    end

    assign bus.count         = count_q;
    assign bus.empty         = (state == ST_EMPTY);
    assign bus.full          = (state == ST_FULL);
    assign bus.err_overflow  = err_ovf_q;
    assign bus.err_underflow = err_unf_q;
    assign bus.bcd_tens      = tens_q;
    assign bus.bcd_ones      = ones_q;

`ifdef PARKING_STATS_EN
    logic [CW-1:0]      peak_q;
    logic [STATS_W-1:0] total_q;

    // Peak tracks the new count in the same cycle the count rises above it.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_q  <= '0;
            total_q <= '0;
        end else if (add_ok) begin
            if ((count_q + ONE) > peak_q) begin
                peak_q <= count_q + ONE;
            end
            if (total_q != {STATS_W{1'b1}}) begin
                total_q <= total_q + STATS_W'(1);
            end
        end
    end

    assign bus.peak          = peak_q;
    assign bus.total_entries = total_q;
`endif

endmodule

// File: tb/tb_parking_occupancy.sv
// Self-checking bench for parking_occupancy at CAPACITY 3 and 25 against an integer reference model.
module tb_parking_occupancy;

    typedef struct {
        int count;
        int bcdSrc;
        bit ovf;
        bit unf;
        int peak;
        int total;
    } model_t;

    logic clk;
    logic reset3;
    logic reset25;
    int   numChecks;
    int   numFails;
    model_t m3;
    model_t m25;

    parking_occupancy_if #(.CAPACITY(3))  bus3 ();
    parking_occupancy_if #(.CAPACITY(25)) bus25 ();

    parking_occupancy #(.CAPACITY(3)) dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (bus3)
    );

    parking_occupancy #(.CAPACITY(25)) dut25 (
        .clk   (clk),
        .reset (reset25),
        .bus   (bus25)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic model_t resetModel();
        model_t r;
        r.count  = 0;
        r.bcdSrc = 0;
        r.ovf    = 1'b0;
        r.unf    = 1'b0;
        r.peak   = 0;
        r.total  = 0;
        return r;
    endfunction

    // Occupancy rules stated in lot terms: lone enter adds a car unless full, lone exit removes one unless empty.
    function automatic model_t stepModel(model_t m, int cap, bit en, bit ex, bit clr, bit rst);
        model_t n;
        bit newOvf;
        bit newUnf;
        if (rst) return resetModel();
        n = m;
        newOvf = 1'b0;
        newUnf = 1'b0;
        n.bcdSrc = m.count;
        if (en && !ex) begin
            if (m.count == cap) newOvf = 1'b1;
            else begin
                n.count = m.count + 1;
                if (n.total < 65535) n.total = m.total + 1;
                if (n.count > n.peak) n.peak = n.count;
            end
        end else if (ex && !en) begin
            if (m.count == 0) newUnf = 1'b1;
            else n.count = m.count - 1;
        end
        n.ovf = (m.ovf && !clr) || newOvf;
        n.unf = (m.unf && !clr) || newUnf;
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("c3_count", 32'(bus3.count), m3.count);
        checkOutput("c3_empty", 32'(bus3.empty), 32'(m3.count == 0));
        checkOutput("c3_full", 32'(bus3.full), 32'(m3.count == 3));
        checkOutput("c3_ovf", 32'(bus3.err_overflow), 32'(m3.ovf));
        checkOutput("c3_unf", 32'(bus3.err_underflow), 32'(m3.unf));
        checkOutput("c3_tens", 32'(bus3.bcd_tens), m3.bcdSrc / 10);
        checkOutput("c3_ones", 32'(bus3.bcd_ones), m3.bcdSrc % 10);
        checkOutput("c25_count", 32'(bus25.count), m25.count);
        checkOutput("c25_empty", 32'(bus25.empty), 32'(m25.count == 0));
        checkOutput("c25_full", 32'(bus25.full), 32'(m25.count == 25));
        checkOutput("c25_ovf", 32'(bus25.err_overflow), 32'(m25.ovf));
        checkOutput("c25_unf", 32'(bus25.err_underflow), 32'(m25.unf));
        checkOutput("c25_tens", 32'(bus25.bcd_tens), m25.bcdSrc / 10);
        checkOutput("c25_ones", 32'(bus25.bcd_ones), m25.bcdSrc % 10);
`ifdef PARKING_STATS_EN
        checkOutput("c3_peak", 32'(bus3.peak), m3.peak);
        checkOutput("c3_total", 32'(bus3.total_entries), m3.total);
        checkOutput("c25_peak", 32'(bus25.peak), m25.peak);
        checkOutput("c25_total", 32'(bus25.total_entries), m25.total);
`endif
    endtask

    // One clock cycle of stimulus to the selected lot; the other lot idles.
    task automatic applyStimulus(input int which, input bit en, input bit ex, input bit clr, input bit rst);
        bit is3;
        bit is25;
        is3  = (which == 3);
        is25 = (which == 25);
        bus3.enter      = is3 && en;
        bus3.exit       = is3 && ex;
        bus3.clear_err  = is3 && clr;
        reset3          = is3 && rst;
        bus25.enter     = is25 && en;
        bus25.exit      = is25 && ex;
        bus25.clear_err = is25 && clr;
        reset25         = is25 && rst;
        @(posedge clk);
        #1;
        m3  = stepModel(m3, 3, is3 && en, is3 && ex, is3 && clr, is3 && rst);
        m25 = stepModel(m25, 25, is25 && en, is25 && ex, is25 && clr, is25 && rst);
        checkAll();
    endtask

    initial begin
        numChecks = 0;
        numFails  = 0;
        bus3.enter = 1'b0;  bus3.exit = 1'b0;  bus3.clear_err = 1'b0;
        bus25.enter = 1'b0; bus25.exit = 1'b0; bus25.clear_err = 1'b0;
        reset3  = 1'b1;
        reset25 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m3  = resetModel();
        m25 = resetModel();
        checkAll();

        repeat (3) applyStimulus(3, 0, 0, 0, 0);
        checkOutput("rst_count", 32'(bus3.count), 0);
        checkOutput("rst_empty", 32'(bus3.empty), 1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(3, 1, 0, 0, 0);
            checkOutput("fill_count", 32'(bus3.count), i + 1);
            applyStimulus(3, 0, 0, 0, 0);
            applyStimulus(3, 0, 0, 0, 0);
        end
        checkOutput("fill_full", 32'(bus3.full), 1);
        checkOutput("fill_ones", 32'(bus3.bcd_ones), 3);

        applyStimulus(3, 1, 0, 0, 0);
        checkOutput("ovf_hold", 32'(bus3.count), 3);
        checkOutput("ovf_flag", 32'(bus3.err_overflow), 1);
        applyStimulus(3, 1, 1, 0, 0);
        checkOutput("both_full", 32'(bus3.count), 3);
        applyStimulus(3, 0, 0, 1, 0);
        checkOutput("ovf_clear", 32'(bus3.err_overflow), 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(3, 0, 1, 0, 0);
            applyStimulus(3, 0, 0, 0, 0);
        end
        checkOutput("drain_empty", 32'(bus3.empty), 1);
        applyStimulus(3, 0, 1, 0, 0);
        checkOutput("unf_flag", 32'(bus3.err_underflow), 1);
        applyStimulus(3, 0, 1, 1, 0);
        checkOutput("unf_clear_race", 32'(bus3.err_underflow), 1);
        applyStimulus(3, 1, 1, 0, 0);
        checkOutput("both_empty", 32'(bus3.count), 0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(25, 1, 0, 0, 0);
            applyStimulus(25, 0, 0, 0, 0);
        end
        checkOutput("bcd12_tens", 32'(bus25.bcd_tens), 1);
        checkOutput("bcd12_ones", 32'(bus25.bcd_ones), 2);
        applyStimulus(25, 1, 0, 0, 0);
        applyStimulus(25, 1, 0, 0, 1);
        checkOutput("midrst_count", 32'(bus25.count), 0);
        checkOutput("midrst_empty", 32'(bus25.empty), 1);
        checkOutput("midrst_tens", 32'(bus25.bcd_tens), 0);

`ifdef PARKING_STATS_EN
        applyStimulus(3, 0, 0, 0, 1);
        repeat (3) applyStimulus(3, 1, 0, 0, 0);
        repeat (2) applyStimulus(3, 0, 1, 0, 0);
        repeat (2) applyStimulus(3, 1, 0, 0, 0);
        applyStimulus(3, 1, 0, 0, 0);
        checkOutput("stats_peak", 32'(bus3.peak), 3);
        checkOutput("stats_total", 32'(bus3.total_entries), 5);
`endif

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 1) == 0) ? 3 : 25,
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", numChecks, numFails);
        $finish;
    end

endmodule
